// File: rtl/packet_receiver_pkg.sv
// Shared definitions for the router FIFO packet stages (receiver and sender).
// Header byte positions, default geometry and the parser state encoding.
package packet_receiver_pkg;

   // Default geometry
   localparam int PKT_UWIDTH    = 8;
   localparam int PKT_PTR_IN_SZ = 4;
   localparam int PKT_MAX_SIZE  = 8;

   // In-packet byte positions of the header fields
   localparam int SRC_IDX  = 0;
   localparam int DST_IDX  = 1;
   localparam int SIZE_IDX = 2;
   localparam int DATA_IDX = 3;

   // Parser states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DEST    = 3'd1,
      ST_SIZE    = 3'd2,
      ST_DATA    = 3'd3,
      ST_CRC     = 3'd4,
      ST_DISCARD = 3'd5
   } pkt_state_e;

endpackage

// File: rtl/packet_receiver_if.sv
// Stream-in / FIFO-write bundle of the packet receiver.
// master: the packet source and FIFO side; slave: the receiver itself.
interface packet_receiver_if #(
   parameter int UWIDTH    = 8,
   parameter int PTR_IN_SZ = 4
) ();

   logic                 packet_valid;
   logic [UWIDTH-1:0]    packet_in;
   logic                 wfull;
   logic                 winc;
   logic [PTR_IN_SZ-1:0] waddr_in;
   logic [UWIDTH-1:0]    wdata;
   logic                 busy;
   logic                 drop;
   logic                 crc_err;

   modport master (
      output packet_valid, packet_in, wfull,
      input  winc, waddr_in, wdata, busy, drop, crc_err
   );

   modport slave (
      input  packet_valid, packet_in, wfull,
      output winc, waddr_in, wdata, busy, drop, crc_err
   );

endinterface

// File: rtl/packet_receiver_crc_acc.sv
// packet_crc_acc: running XOR over the bytes of one packet.
// clr loads the first byte (src_id), en folds in each following header/data byte.
// Only instantiated when PACKET_RECEIVER_CRC_CHECK_EN is defined.
module packet_crc_acc #(
   parameter int UWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [UWIDTH-1:0] din,
   output logic [UWIDTH-1:0] acc
);

   logic [UWIDTH-1:0] acc_q;
   logic [UWIDTH-1:0] acc_d;

   // Next accumulator value: restart on clr, fold byte in on en, else hold
   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = din;
      end else if (en) begin
         acc_d = acc_q ^ din;
      end else begin
         acc_d = acc_q;
      end
   end

   // Accumulator register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/packet_receiver.sv
// packet_receiver: write-side framing stage of the router FIFO.
// Parses src_id, dest_id, size, size data bytes, crc from a packet_valid-framed
// byte stream, writes each byte at its in-packet index and commits the packet
// with a winc pulse alongside the crc byte. Malformed, aborted or FIFO-full
// packets are dropped without ever raising winc.
// Optional feature macro: PACKET_RECEIVER_CRC_CHECK_EN (XOR crc check).
module packet_receiver
   import packet_receiver_pkg::*;
#(
   parameter int UWIDTH    = PKT_UWIDTH,
   parameter int PTR_IN_SZ = PKT_PTR_IN_SZ,
   parameter int MAX_SIZE  = PKT_MAX_SIZE
) (
   input logic               clk,
   input logic               rst,
   packet_receiver_if.slave  bus
);

   localparam logic [PTR_IN_SZ-1:0] IDX_SRC  = PTR_IN_SZ'(SRC_IDX);
   localparam logic [PTR_IN_SZ-1:0] IDX_DST  = PTR_IN_SZ'(DST_IDX);
   localparam logic [PTR_IN_SZ-1:0] IDX_SIZE = PTR_IN_SZ'(SIZE_IDX);
   localparam logic [PTR_IN_SZ-1:0] IDX_DATA = PTR_IN_SZ'(DATA_IDX);
   localparam logic [UWIDTH-1:0]    MAX_SIZE_B = UWIDTH'(MAX_SIZE);

   pkt_state_e           state_q,   state_d;
   logic [PTR_IN_SZ-1:0] dcnt_q,    dcnt_d;
   logic [PTR_IN_SZ-1:0] size_q,    size_d;
   logic                 winc_q,    winc_d;
   logic [PTR_IN_SZ-1:0] waddr_q,   waddr_d;
   logic [UWIDTH-1:0]    wdata_q,   wdata_d;
   logic                 busy_q,    busy_d;
   logic                 drop_q,    drop_d;
   logic                 crc_err_q, crc_err_d;
   logic                 crc_ok_s;

`ifdef PACKET_RECEIVER_CRC_CHECK_EN
   logic              acc_clr_s;
   logic              acc_en_s;
   logic [UWIDTH-1:0] acc_s;

   // src_id restarts the checksum; dest, size and data bytes fold into it
   assign acc_clr_s = bus.packet_valid && (state_q == ST_IDLE);
   assign acc_en_s  = bus.packet_valid &&
                      ((state_q == ST_DEST) || (state_q == ST_SIZE) || (state_q == ST_DATA));

   packet_crc_acc #(.UWIDTH(UWIDTH)) u_crc_acc (
      .clk (clk),
      .rst (rst),
      .clr (acc_clr_s),
      .en  (acc_en_s),
      .din (bus.packet_in),
      .acc (acc_s)
   );

   assign crc_ok_s = (acc_s == bus.packet_in);
`else
   // crc byte is stored without being checked
   assign crc_ok_s = 1'b1;
`endif

   // Parser next-state and next-output computation
   always_comb begin
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      size_d    = size_q;
      winc_d    = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      drop_d    = 1'b0;
      crc_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.packet_valid) begin
               waddr_d = IDX_SRC;
               wdata_d = bus.packet_in;
               if (bus.wfull) begin
                  state_d = ST_DISCARD;
                  drop_d  = 1'b1;
               end else begin
                  state_d = ST_DEST;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_DEST: begin
            if (bus.packet_valid) begin
               waddr_d = IDX_DST;
               wdata_d = bus.packet_in;
               state_d = ST_SIZE;
            end else begin
               state_d = ST_IDLE;
               drop_d  = 1'b1;
            end
         end

         ST_SIZE: begin
            if (bus.packet_valid) begin
               // A bad size byte still lands on wdata; without winc it is never committed
               waddr_d = IDX_SIZE;
               wdata_d = bus.packet_in;
               size_d  = bus.packet_in[PTR_IN_SZ-1:0];
               if ((bus.packet_in == {UWIDTH{1'b0}}) || (bus.packet_in > MAX_SIZE_B)) begin
                  state_d = ST_DISCARD;
                  drop_d  = 1'b1;
               end else begin
                  dcnt_d  = {PTR_IN_SZ{1'b0}};
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_IDLE;
               drop_d  = 1'b1;
            end
         end

         ST_DATA: begin
            if (bus.packet_valid) begin
               waddr_d = IDX_DATA + dcnt_q;
               wdata_d = bus.packet_in;
               dcnt_d  = dcnt_q + {{(PTR_IN_SZ-1){1'b0}}, 1'b1};
               if (dcnt_q == (size_q - {{(PTR_IN_SZ-1){1'b0}}, 1'b1})) begin
                  state_d = ST_CRC;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_IDLE;
               drop_d  = 1'b1;
            end
         end

         ST_CRC: begin
            if (bus.packet_valid) begin
               waddr_d = IDX_DATA + size_q;
               wdata_d = bus.packet_in;
               state_d = ST_IDLE;
               if (bus.wfull || !crc_ok_s) begin
                  drop_d    = 1'b1;
                  crc_err_d = !crc_ok_s;
               end else begin
                  winc_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
               drop_d  = 1'b1;
            end
         end

         ST_DISCARD: begin
            // Swallow the rest of the packet; outputs hold
            if (bus.packet_valid) begin
               state_d = ST_DISCARD;
            end else begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         dcnt_q    <= {PTR_IN_SZ{1'b0}};
         size_q    <= {PTR_IN_SZ{1'b0}};
         winc_q    <= 1'b0;
         waddr_q   <= {PTR_IN_SZ{1'b0}};
         wdata_q   <= {UWIDTH{1'b0}};
         busy_q    <= 1'b0;
         drop_q    <= 1'b0;
         crc_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dcnt_q    <= dcnt_d;
         size_q    <= size_d;
         winc_q    <= winc_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         busy_q    <= busy_d;
         drop_q    <= drop_d;
         crc_err_q <= crc_err_d;
      end
   end

   assign bus.winc     = winc_q;
   assign bus.waddr_in = waddr_q;
   assign bus.wdata    = wdata_q;
   assign bus.busy     = busy_q;
   assign bus.drop     = drop_q;
   assign bus.crc_err  = crc_err_q;

endmodule

// File: tb/tb_packet_receiver.sv
// Directed, table-driven bench for packet_receiver (UWIDTH=8, PTR_IN_SZ=4, MAX_SIZE=8).
// Each row: one clock of stimulus and the outputs expected right after that edge.
module tb_packet_receiver;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   packet_receiver_if #(.UWIDTH(8), .PTR_IN_SZ(4)) bus ();

   packet_receiver #(.UWIDTH(8), .PTR_IN_SZ(4), .MAX_SIZE(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        r;
      logic        v;
      logic [7:0]  d;
      logic        f;
      logic [15:0] exp;   // {winc, waddr_in[3:0], wdata[7:0], busy, drop, crc_err}
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic logic [15:0] e(input logic w, input logic [3:0] a, input logic [7:0] d,
                                     input logic b, input logic dr, input logic c);
      return {w, a, d, b, dr, c};
   endfunction

   function automatic logic [15:0] outs();
      return {bus.winc, bus.waddr_in, bus.wdata, bus.busy, bus.drop, bus.crc_err};
   endfunction

   task automatic add(input logic r, input logic v, input logic [7:0] d, input logic f,
                      input logic [15:0] exp);
      vec_t t;
      t.r = r; t.v = v; t.d = d; t.f = f; t.exp = exp;
      vecs.push_back(t);
   endtask

   task automatic apply(input logic r, input logic v, input logic [7:0] d, input logic f);
      @(negedge clk);
      rst              = r;
      bus.packet_valid = v;
      bus.packet_in    = d;
      bus.wfull        = f;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] exp);
      logic [15:0] got;
      got = outs();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: {winc,addr,data,busy,drop,crc_err} got w=%b a=%0d d=%0d b=%b dr=%b c=%b required w=%b a=%0d d=%0d b=%b dr=%b c=%b",
                  name, got[15], got[14:11], got[10:3], got[2], got[1], got[0],
                  exp[15], exp[14:11], exp[10:3], exp[2], exp[1], exp[0]);
      end
   endtask

   initial begin
      rst              = 1'b1;
      bus.packet_valid = 1'b0;
      bus.packet_in    = 8'd0;
      bus.wfull        = 1'b0;

      // 1. Clean packet 10,160,3,0,1,2,crc 170
      add(0,1,8'd10 ,0, e(0,4'd0,8'd10 ,1,0,0));
      add(0,1,8'd160,0, e(0,4'd1,8'd160,1,0,0));
      add(0,1,8'd3  ,0, e(0,4'd2,8'd3  ,1,0,0));
      add(0,1,8'd0  ,0, e(0,4'd3,8'd0  ,1,0,0));
      add(0,1,8'd1  ,0, e(0,4'd4,8'd1  ,1,0,0));
      add(0,1,8'd2  ,0, e(0,4'd5,8'd2  ,1,0,0));
      add(0,1,8'd170,0, e(1,4'd6,8'd170,0,0,0));
      // 2. Back-to-back 100,10,4,0,1,2,3,crc 106
      add(0,1,8'd100,0, e(0,4'd0,8'd100,1,0,0));
      add(0,1,8'd10 ,0, e(0,4'd1,8'd10 ,1,0,0));
      add(0,1,8'd4  ,0, e(0,4'd2,8'd4  ,1,0,0));
      add(0,1,8'd0  ,0, e(0,4'd3,8'd0  ,1,0,0));
      add(0,1,8'd1  ,0, e(0,4'd4,8'd1  ,1,0,0));
      add(0,1,8'd2  ,0, e(0,4'd5,8'd2  ,1,0,0));
      add(0,1,8'd3  ,0, e(0,4'd6,8'd3  ,1,0,0));
      add(0,1,8'd106,0, e(1,4'd7,8'd106,0,0,0));
      add(0,0,8'd0  ,0, e(0,4'd7,8'd106,0,0,0));
      // 3a. size 0 -> discard
      add(0,1,8'd20 ,0, e(0,4'd0,8'd20 ,1,0,0));
      add(0,1,8'd21 ,0, e(0,4'd1,8'd21 ,1,0,0));
      add(0,1,8'd0  ,0, e(0,4'd2,8'd0  ,1,1,0));
      add(0,1,8'd55 ,0, e(0,4'd2,8'd0  ,1,0,0));
      add(0,0,8'd0  ,0, e(0,4'd2,8'd0  ,0,0,0));
      // 3b. size 9 > MAX_SIZE -> discard
      add(0,1,8'd30 ,0, e(0,4'd0,8'd30 ,1,0,0));
      add(0,1,8'd31 ,0, e(0,4'd1,8'd31 ,1,0,0));
      add(0,1,8'd9  ,0, e(0,4'd2,8'd9  ,1,1,0));
      add(0,1,8'd77 ,0, e(0,4'd2,8'd9  ,1,0,0));
      add(0,0,8'd0  ,0, e(0,4'd2,8'd9  ,0,0,0));
      // 4. wfull at src -> discard, then 50,51,1,7,crc 7 written
      add(0,1,8'd40 ,1, e(0,4'd0,8'd40 ,1,1,0));
      add(0,1,8'd41 ,1, e(0,4'd0,8'd40 ,1,0,0));
      add(0,1,8'd2  ,0, e(0,4'd0,8'd40 ,1,0,0));
      add(0,0,8'd0  ,0, e(0,4'd0,8'd40 ,0,0,0));
      add(0,1,8'd50 ,0, e(0,4'd0,8'd50 ,1,0,0));
      add(0,1,8'd51 ,0, e(0,4'd1,8'd51 ,1,0,0));
      add(0,1,8'd1  ,0, e(0,4'd2,8'd1  ,1,0,0));
      add(0,1,8'd7  ,0, e(0,4'd3,8'd7  ,1,0,0));
      add(0,1,8'd7  ,0, e(1,4'd4,8'd7  ,0,0,0));
      // 4b. wfull at crc byte -> drop, no winc
      add(0,0,8'd0  ,0, e(0,4'd4,8'd7  ,0,0,0));
      add(0,1,8'd60 ,0, e(0,4'd0,8'd60 ,1,0,0));
      add(0,1,8'd61 ,0, e(0,4'd1,8'd61 ,1,0,0));
      add(0,1,8'd1  ,0, e(0,4'd2,8'd1  ,1,0,0));
      add(0,1,8'd5  ,0, e(0,4'd3,8'd5  ,1,0,0));
      add(0,1,8'd5  ,1, e(0,4'd4,8'd5  ,0,1,0));
      // 5a. abort after 2nd data byte
      add(0,1,8'd70 ,0, e(0,4'd0,8'd70 ,1,0,0));
      add(0,1,8'd71 ,0, e(0,4'd1,8'd71 ,1,0,0));
      add(0,1,8'd4  ,0, e(0,4'd2,8'd4  ,1,0,0));
      add(0,1,8'hAA ,0, e(0,4'd3,8'hAA ,1,0,0));
      add(0,1,8'hBB ,0, e(0,4'd4,8'hBB ,1,0,0));
      add(0,0,8'd0  ,0, e(0,4'd4,8'hBB ,0,1,0));
      add(0,0,8'd0  ,0, e(0,4'd4,8'hBB ,0,0,0));
      // 5b. rst mid-packet -> everything cleared, no drop
      add(0,1,8'd80 ,0, e(0,4'd0,8'd80 ,1,0,0));
      add(0,1,8'd81 ,0, e(0,4'd1,8'd81 ,1,0,0));
      add(1,1,8'd82 ,0, e(0,4'd0,8'd0  ,0,0,0));
      add(0,0,8'd0  ,0, e(0,4'd0,8'd0  ,0,0,0));
      // after reset a fresh packet starts at index 0
      add(0,1,8'd90 ,0, e(0,4'd0,8'd90 ,1,0,0));
      add(0,0,8'd0  ,0, e(0,4'd0,8'd90 ,0,1,0));

      // Reset state
      apply(1,0,8'd0,0);
      apply(1,0,8'd0,0);
      check("reset", e(0,4'd0,8'd0,0,0,0));

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].f);
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // 6. Packet 1 with a wrong crc (15 instead of 170)
      apply(0,1,8'd10 ,0);
      apply(0,1,8'd160,0);
      apply(0,1,8'd3  ,0);
      apply(0,1,8'd0  ,0);
      apply(0,1,8'd1  ,0);
      apply(0,1,8'd2  ,0);
      check("badcrc_pre", e(0,4'd5,8'd2,1,0,0));
      apply(0,1,8'd15 ,0);
`ifdef PACKET_RECEIVER_CRC_CHECK_EN
      check("badcrc", e(0,4'd6,8'd15,0,1,1));
`else
      check("badcrc", e(1,4'd6,8'd15,0,0,0));
`endif
      apply(0,0,8'd0,0);
      check("badcrc_after", e(0,4'd6,8'd15,0,0,0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
